// File: rtl/sim_exit_monitor.sv
// Polls tohost exit words from several harts on a fixed period and folds the
// per-hart exits into one sticky finish / fail / exit-code status with a watchdog.
module sim_exit_monitor #(
    parameter int NrHarts      = 8,
    parameter int ExitW        = 32,
    parameter int PollCycles   = 200,
    parameter int TimeoutTicks = 0,
    parameter bit WaitAll      = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NrHarts-1:0]         hart_active_i,
    input  logic [NrHarts-1:0]         exit_valid_i,
    input  logic [NrHarts*ExitW-1:0]   exit_word_i,
    output logic [NrHarts-1:0]         exit_ready_o,
    output logic                       poll_o,
    output logic                       done_o,
    output logic                       fail_o,
    output logic                       timeout_o,
    output logic [ExitW-2:0]           exit_code_o,
    output logic [(NrHarts>1 ? $clog2(NrHarts) : 1)-1:0] fail_hart_o
);

    localparam int CodeW = ExitW - 1;
    localparam int HartW = (NrHarts > 1) ? $clog2(NrHarts) : 1;
    localparam int CntW  = (PollCycles > 1) ? $clog2(PollCycles) : 1;
    localparam int TickW = (TimeoutTicks > 0) ? $clog2(TimeoutTicks + 1) : 1;
    localparam logic [CntW-1:0]  CntLast  = CntW'(PollCycles - 1);
    localparam logic [TickW-1:0] TickLast = TickW'((TimeoutTicks > 0) ? TimeoutTicks - 1 : 0);

    typedef enum logic {RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CntW-1:0]    poll_cnt_q;
    logic [TickW-1:0]   tick_cnt_q;
    logic [NrHarts-1:0] hart_done_q;
    logic               fail_q, timeout_q;
    logic [CodeW-1:0]   code_q;
    logic [HartW-1:0]   fail_hart_q;

    logic               poll, tick_run, finish, timeout_hit;
    logic               any_fail, hart_done_all;
    logic [NrHarts-1:0] exit_acc, fail_acc;
    logic [ExitW-1:0]   word;
    logic [CodeW-1:0]   first_exit_code, first_fail_code;
    logic [HartW-1:0]   first_fail_hart;

    // Poll tick is forced low while reset is held so every output reads 0.
    assign poll     = ~rst_i & (poll_cnt_q == CntLast);
    assign tick_run = poll & (state_q == RUN);

    assign exit_ready_o = {NrHarts{tick_run}} & hart_active_i & ~hart_done_q & exit_valid_i;

    // Downward scan so the lowest exiting / failing hart is the one that sticks.
    always_comb begin
        exit_acc        = '0;
        fail_acc        = '0;
        word            = '0;
        first_exit_code = '0;
        first_fail_code = '0;
        first_fail_hart = '0;
        for (int i = NrHarts - 1; i >= 0; i--) begin
            word = exit_word_i[i*ExitW +: ExitW];
            if (exit_ready_o[i] && word[0]) begin
                exit_acc[i]     = 1'b1;
                first_exit_code = word[ExitW-1:1];
                if (word[ExitW-1:1] != '0) begin
                    fail_acc[i]     = 1'b1;
                    first_fail_code = word[ExitW-1:1];
                    first_fail_hart = HartW'(i);
                end
            end
        end
    end

    assign any_fail      = |fail_acc;
    assign hart_done_all = &(hart_done_q | exit_acc | ~hart_active_i);
    assign finish        = tick_run & (WaitAll ? (hart_done_all | any_fail) : (|exit_acc));
    // An exit landing on the same tick as the watchdog limit wins.
    assign timeout_hit   = (TimeoutTicks != 0) && tick_run && (tick_cnt_q == TickLast) && !finish;

    always_comb begin
        state_d = state_q;
        if (state_q == RUN && (finish || timeout_hit)) begin
            state_d = DONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            poll_cnt_q  <= '0;
            tick_cnt_q  <= '0;
            hart_done_q <= '0;
        end else begin
            poll_cnt_q  <= (poll_cnt_q == CntLast) ? '0 : poll_cnt_q + CntW'(1);
            if (tick_run) begin
                tick_cnt_q <= tick_cnt_q + TickW'(1);
            end
            hart_done_q <= hart_done_q | exit_acc;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            code_q      <= '0;
            fail_hart_q <= '0;
        end else if (state_q == RUN && state_d == DONE) begin
            if (timeout_hit) begin
                fail_q      <= 1'b1;
                timeout_q   <= 1'b1;
                code_q      <= '1;
                fail_hart_q <= '0;
            end else begin
                fail_q      <= any_fail;
                code_q      <= any_fail ? first_fail_code : first_exit_code;
                fail_hart_q <= any_fail ? first_fail_hart : '0;
            end
        end
    end

    assign poll_o      = poll;
    assign done_o      = (state_q == DONE);
    assign fail_o      = fail_q;
    assign timeout_o   = timeout_q;
    assign exit_code_o = code_q;
    assign fail_hart_o = fail_hart_q;

endmodule

// File: tb/tb_sim_exit_monitor.sv
// Scoreboard bench for sim_exit_monitor: one 4-hart instance for exit scenarios,
// a second one with a 3-tick watchdog and no exits.
module tb_sim_exit_monitor;

    localparam int N = 4;
    localparam int W = 32;
    localparam int P = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_a, rst_b;
    logic [N-1:0]   active_a, valid_a, ready_a;
    logic [N*W-1:0] words_a;
    logic           poll_a, done_a, fail_a, timeout_a;
    logic [W-2:0]   code_a;
    logic [1:0]     hart_a;

    logic [N-1:0]   active_b, valid_b, ready_b;
    logic [N*W-1:0] words_b;
    logic           poll_b, done_b, fail_b, timeout_b;
    logic [W-2:0]   code_b;
    logic [1:0]     hart_b;

    sim_exit_monitor #(.NrHarts(N), .ExitW(W), .PollCycles(P), .TimeoutTicks(0), .WaitAll(1'b1)) u_dut_a (
        .clk_i(clk), .rst_i(rst_a), .hart_active_i(active_a), .exit_valid_i(valid_a),
        .exit_word_i(words_a), .exit_ready_o(ready_a), .poll_o(poll_a), .done_o(done_a),
        .fail_o(fail_a), .timeout_o(timeout_a), .exit_code_o(code_a), .fail_hart_o(hart_a));

    sim_exit_monitor #(.NrHarts(N), .ExitW(W), .PollCycles(P), .TimeoutTicks(3), .WaitAll(1'b1)) u_dut_b (
        .clk_i(clk), .rst_i(rst_b), .hart_active_i(active_b), .exit_valid_i(valid_b),
        .exit_word_i(words_b), .exit_ready_o(ready_b), .poll_o(poll_b), .done_o(done_b),
        .fail_o(fail_b), .timeout_o(timeout_b), .exit_code_o(code_b), .fail_hart_o(hart_b));

    typedef struct {
        bit           is_done;
        logic [N-1:0] mask;
        bit           fail;
        bit           tmo;
        logic [W-2:0] code;
        logic [1:0]   hart;
    } exp_t;

    exp_t q[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;
    bit   b_finished = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic exp_t acc(input logic [N-1:0] m);
        exp_t e;
        e = '{is_done: 1'b0, mask: m, fail: 1'b0, tmo: 1'b0, code: '0, hart: '0};
        return e;
    endfunction

    function automatic exp_t fin(input bit f, input bit t, input logic [W-2:0] c, input logic [1:0] h);
        exp_t e;
        e = '{is_done: 1'b1, mask: '0, fail: f, tmo: t, code: c, hart: h};
        return e;
    endfunction

    function automatic logic [N*W-1:0] pk(input logic [W-1:0] w0, input logic [W-1:0] w1,
                                          input logic [W-1:0] w2, input logic [W-1:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    // Present words until the next poll tick, then withdraw them.
    task automatic present(input logic [N-1:0] mask, input logic [N*W-1:0] wv);
        int k;
        @(posedge clk); #1;
        valid_a = mask;
        words_a = wv;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!poll_a && k < 100);
        if (!poll_a) begin
            checks++;
            errors++;
            $display("FAIL present_no_poll: got 0 expected 1 at %0t", $time);
        end
        @(posedge clk); #1;
        valid_a = '0;
    endtask

    task automatic hold_idle(input logic [N-1:0] mask, input int nticks);
        int k;
        @(posedge clk); #1;
        valid_a = mask;
        words_a = pk(32'h1, 32'h1, 32'h1, 32'h1);
        for (int t = 0; t < nticks; t++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!poll_a && k < 100);
            chk("ready_after_done", 32'(ready_a), 32'h0);
        end
        @(posedge clk); #1;
        valid_a = '0;
    endtask

    task automatic reset_a();
        @(posedge clk); #1;
        rst_a = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    initial begin : mon_a
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_a) begin
                prev = 1'b0;
            end else begin
                if (ready_a != '0) begin
                    if (q.size() == 0 || q[0].is_done) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_accept: got %b expected none at %0t", ready_a, $time);
                    end else begin
                        e = q.pop_front();
                        chk("accept_mask", 32'(ready_a), 32'(e.mask));
                    end
                end
                if (done_a && !prev) begin
                    if (q.size() == 0 || !q[0].is_done) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got 1 expected 0 at %0t", $time);
                    end else begin
                        e = q.pop_front();
                        chk("done_fail", 32'(fail_a), 32'(e.fail));
                        chk("done_timeout", 32'(timeout_a), 32'(e.tmo));
                        chk("done_code", 32'(code_a), 32'(e.code));
                        chk("done_hart", 32'(hart_a), 32'(e.hart));
                    end
                end
                prev = done_a;
            end
        end
    end

    initial begin : mon_b
        int   ticks;
        bit   prev_poll, prev_done, seen;
        exp_t e;
        ticks = 0; prev_poll = 1'b0; prev_done = 1'b0; seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (!rst_b) begin
                if (done_b && !prev_done) begin
                    seen = 1'b1;
                    if (qb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wd_unexpected_done: got 1 expected 0 at %0t", $time);
                    end else begin
                        e = qb.pop_front();
                        chk("wd_ticks", 32'(ticks), 32'd3);
                        chk("wd_prev_poll", 32'(prev_poll), 32'd1);
                        chk("wd_timeout", 32'(timeout_b), 32'(e.tmo));
                        chk("wd_fail", 32'(fail_b), 32'(e.fail));
                        chk("wd_code", 32'(code_b), 32'(e.code));
                        chk("wd_hart", 32'(hart_b), 32'(e.hart));
                    end
                end
                if (poll_b) ticks++;
                prev_poll = poll_b;
                prev_done = done_b;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wd_never_done: got 0 expected 1");
        end
        b_finished = 1'b1;
    end

    initial begin : stim
        int k;
        rst_a = 1'b1; rst_b = 1'b1;
        active_a = '1; valid_a = '0; words_a = '0;
        active_b = '1; valid_b = '0; words_b = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_done", 32'(done_a), 32'h0);
        chk("rst_fail", 32'(fail_a), 32'h0);
        chk("rst_timeout", 32'(timeout_a), 32'h0);
        chk("rst_code", 32'(code_a), 32'h0);
        chk("rst_hart", 32'(hart_a), 32'h0);
        chk("rst_poll", 32'(poll_a), 32'h0);
        chk("rst_ready", 32'(ready_a), 32'h0);
        chk("rst_b_outputs", {26'd0, done_b, fail_b, timeout_b, poll_b, hart_b}, 32'h0);
        chk("rst_b_ready", 32'(ready_b), 32'h0);

        qb.push_back(fin(1'b1, 1'b1, {(W-1){1'b1}}, 2'd0));
        @(posedge clk); #1;
        rst_a = 1'b0; rst_b = 1'b0;

        // All four harts exit cleanly on separate ticks.
        for (int h = 0; h < N; h++) begin
            q.push_back(acc(4'(1 << h)));
            if (h == N - 1) q.push_back(fin(1'b0, 1'b0, '0, 2'd0));
            present(4'(1 << h), pk(32'h1, 32'h1, 32'h1, 32'h1));
        end
        settle();
        chk("t1_drained", 32'(q.size()), 32'd0);

        // Hart 2 fails while others still run; nobody is accepted afterwards.
        reset_a();
        q.push_back(acc(4'b0001));
        present(4'b0001, pk(32'h1, 32'h1, 32'h1, 32'h1));
        q.push_back(acc(4'b0100));
        q.push_back(fin(1'b1, 1'b0, 31'd3, 2'd2));
        present(4'b0100, pk(32'h1, 32'h1, 32'h7, 32'h1));
        hold_idle(4'b1011, 2);
        chk("t2_sticky_done", 32'(done_a), 32'h1);
        chk("t2_sticky_code", 32'(code_a), 32'd3);
        @(posedge clk); #3;
        rst_a = 1'b1;
        #1;
        chk("async_rst_clears", {28'd0, done_a, fail_a, timeout_a, poll_a}, 32'h0);
        chk("async_rst_code", 32'(code_a), 32'h0);
        chk("async_rst_hart", 32'(hart_a), 32'h0);
        @(posedge clk); #1;
        rst_a = 1'b0;

        // Harts 1 and 3 fail on the same tick: the lower index wins.
        q.push_back(acc(4'b1010));
        q.push_back(fin(1'b1, 1'b0, 31'd5, 2'd1));
        present(4'b1010, pk(32'h1, 32'hB, 32'h1, 32'h13));
        settle();

        // Non-exit syscall is consumed without finishing.
        reset_a();
        q.push_back(acc(4'b0001));
        present(4'b0001, pk(32'h10, 32'h1, 32'h1, 32'h1));
        repeat (2 * P) @(negedge clk);
        chk("t4_no_done", 32'(done_a), 32'h0);
        q.push_back(acc(4'b1111));
        q.push_back(fin(1'b0, 1'b0, '0, 2'd0));
        present(4'b1111, pk(32'h1, 32'h1, 32'h1, 32'h1));
        settle();

        // Reset after a hart exit, then finish with a partial active mask.
        reset_a();
        q.push_back(acc(4'b0001));
        present(4'b0001, pk(32'h1, 32'h1, 32'h1, 32'h1));
        @(posedge clk); #1;
        rst_a = 1'b1;
        active_a = 4'b0101;
        #1;
        chk("t6_rst_done", 32'(done_a), 32'h0);
        @(posedge clk); #1;
        rst_a = 1'b0;
        q.push_back(acc(4'b0101));
        q.push_back(fin(1'b0, 1'b0, '0, 2'd0));
        present(4'b0101, pk(32'h1, 32'h1, 32'h1, 32'h1));
        settle();

        // No active harts: finishes on the first tick.
        @(posedge clk); #1;
        rst_a = 1'b1;
        active_a = 4'b0000;
        @(posedge clk); #1;
        rst_a = 1'b0;
        q.push_back(fin(1'b0, 1'b0, '0, 2'd0));
        k = 0;
        while (!done_a && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("t7_empty_mask_done", 32'(done_a), 32'h1);
        settle();

        k = 0;
        while (!b_finished && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("wd_monitor_finished", 32'(b_finished), 32'h1);
        chk("final_drained", 32'(q.size()), 32'd0);
        chk("final_wd_drained", 32'(qb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
